// File: rtl/usb_desc_streamer.sv
// EP0 GET_DESCRIPTOR engine: looks up a ROM region, clips to wLength and
// streams it as MAXPKT-sized packets with ZLP termination and stall handling.
module usb_desc_streamer #(
    parameter int unsigned MAXPKT    = 64,
    parameter bit          HSSUPPORT = 1'b1
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        i_req_valid,
    input  logic [7:0]  i_req_type,
    input  logic [15:0] i_req_wlength,
    input  logic        i_hs_mode,
    input  logic        i_abort,
    output logic [9:0]  o_descrom_raddr,
    input  logic [7:0]  i_descrom_rdat,
    input  logic [9:0]  i_desc_dev_addr,
    input  logic [7:0]  i_desc_dev_len,
    input  logic [9:0]  i_desc_qual_addr,
    input  logic [7:0]  i_desc_qual_len,
    input  logic [9:0]  i_desc_fscfg_addr,
    input  logic [7:0]  i_desc_fscfg_len,
    input  logic [9:0]  i_desc_hscfg_addr,
    input  logic [7:0]  i_desc_hscfg_len,
    output logic        o_tx_valid,
    output logic [7:0]  o_tx_data,
    output logic        o_tx_last,
    output logic        o_tx_zlp,
    input  logic        i_tx_ready,
    input  logic        i_pkt_ack,
    output logic        o_req_stall,
    output logic        o_done,
    output logic        o_busy
);

    localparam int unsigned PCW = $clog2(MAXPKT) + 1;

    typedef enum logic [2:0] {IDLE, LOOKUP, SEND, WAIT_ACK, ZLP, DONE} state_t;

    state_t          state, state_nx;
    logic [7:0]      type_q;
    logic [15:0]     wlen_q;
    logic            hs_q;
    logic [9:0]      ptr_q;
    logic [15:0]     rem_q;
    logic [15:0]     total_q;
    logic [PCW-1:0]  pc_q;
    logic            stall_q;

    logic            sel_ok;
    logic [9:0]      sel_base;
    logic [7:0]      sel_len;
    logic [15:0]     clip_len;
    logic            last_byte;
    logic            pkt_full;

    // Region select from the latched descriptor type
    always_comb begin
        sel_ok   = 1'b1;
        sel_base = 10'd0;
        sel_len  = 8'd0;
        case (type_q)
            8'd1: begin
                sel_base = i_desc_dev_addr;
                sel_len  = i_desc_dev_len;
            end
            8'd2: begin
                sel_base = hs_q ? i_desc_hscfg_addr : i_desc_fscfg_addr;
                sel_len  = hs_q ? i_desc_hscfg_len  : i_desc_fscfg_len;
            end
            8'd6: begin
                sel_ok   = HSSUPPORT;
                sel_base = i_desc_qual_addr;
                sel_len  = i_desc_qual_len;
            end
            default: sel_ok = 1'b0;
        endcase
    end

    assign clip_len  = ({8'd0, sel_len} < wlen_q) ? {8'd0, sel_len} : wlen_q;
    assign last_byte = (rem_q == 16'd1) || (pc_q == PCW'(MAXPKT - 1));
    assign pkt_full  = (pc_q == PCW'(MAXPKT));

    always_ff @(posedge CLK) begin
        if (!RESET) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx        = state;
        o_tx_valid      = 1'b0;
        o_tx_data       = 8'd0;
        o_tx_last       = 1'b0;
        o_tx_zlp        = 1'b0;
        o_descrom_raddr = 10'd0;
        o_done          = 1'b0;
        o_busy          = (state != IDLE);
        case (state)
            IDLE: if (i_req_valid) state_nx = LOOKUP;
            LOOKUP: begin
                if (!sel_ok)              state_nx = IDLE;
                else if (clip_len == '0)  state_nx = DONE;
                else                      state_nx = SEND;
            end
            SEND: begin
                o_tx_valid      = 1'b1;
                o_descrom_raddr = ptr_q;
                o_tx_data       = i_descrom_rdat;
                o_tx_last       = last_byte;
                if (i_tx_ready && last_byte) state_nx = WAIT_ACK;
            end
            WAIT_ACK: begin
                if (i_pkt_ack) begin
                    if (rem_q != '0)                         state_nx = SEND;
                    else if (pkt_full && (total_q < wlen_q)) state_nx = ZLP;
                    else                                     state_nx = DONE;
                end
            end
            ZLP: begin
                o_tx_valid = 1'b1;
                o_tx_zlp   = 1'b1;
                o_tx_last  = 1'b1;
                if (i_tx_ready) state_nx = WAIT_ACK;
            end
            DONE: begin
                o_done   = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
        if (i_abort) state_nx = IDLE;
    end

    assign o_req_stall = stall_q;

    // Transfer bookkeeping; LOOKUP reinitialises everything, so abort needs no clearing
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            type_q  <= 8'd0;
            wlen_q  <= 16'd0;
            hs_q    <= 1'b0;
            ptr_q   <= 10'd0;
            rem_q   <= 16'd0;
            total_q <= 16'd0;
            pc_q    <= '0;
            stall_q <= 1'b0;
        end else begin
            stall_q <= (state == LOOKUP) && !sel_ok && !i_abort;
            case (state)
                IDLE: begin
                    if (i_req_valid) begin
                        type_q <= i_req_type;
                        wlen_q <= i_req_wlength;
                        hs_q   <= i_hs_mode;
                    end
                end
                LOOKUP: begin
                    ptr_q   <= sel_base;
                    rem_q   <= clip_len;
                    pc_q    <= '0;
                    total_q <= 16'd0;
                end
                SEND: begin
                    if (i_tx_ready) begin
                        ptr_q   <= ptr_q + 10'd1;
                        rem_q   <= rem_q - 16'd1;
                        pc_q    <= pc_q + PCW'(1);
                        total_q <= total_q + 16'd1;
                    end
                end
                WAIT_ACK: if (i_pkt_ack && (rem_q != '0)) pc_q <= '0;
                ZLP:      if (i_tx_ready) pc_q <= '0;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_usb_desc_streamer.sv
// Directed bench for usb_desc_streamer with MAXPKT=8 and no high-speed support.
module tb_usb_desc_streamer;

    localparam int unsigned MAXPKT = 8;
    localparam int DEV_BASE = 16, DEV_LEN = 18;
    localparam int HS_BASE = 256, HS_LEN = 32;
    localparam int FS_BASE = 512, FS_LEN = 25;
    localparam int QU_BASE = 768, QU_LEN = 10;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, hs_mode, abort_in, tx_ready, pkt_ack;
    logic [7:0]  req_type;
    logic [15:0] req_wlength;
    logic [9:0]  rom_addr;
    logic [7:0]  rom_data;
    logic        tx_valid, tx_last, tx_zlp, req_stall, done, busy;
    logic [7:0]  tx_data;
    logic [7:0]  rom [0:1023];

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    assign rom_data = rom[rom_addr];

    usb_desc_streamer #(.MAXPKT(MAXPKT), .HSSUPPORT(1'b0)) dut (
        .CLK(clk), .RESET(rst_n),
        .i_req_valid(req_valid), .i_req_type(req_type), .i_req_wlength(req_wlength),
        .i_hs_mode(hs_mode), .i_abort(abort_in),
        .o_descrom_raddr(rom_addr), .i_descrom_rdat(rom_data),
        .i_desc_dev_addr(10'(DEV_BASE)), .i_desc_dev_len(8'(DEV_LEN)),
        .i_desc_qual_addr(10'(QU_BASE)), .i_desc_qual_len(8'(QU_LEN)),
        .i_desc_fscfg_addr(10'(FS_BASE)), .i_desc_fscfg_len(8'(FS_LEN)),
        .i_desc_hscfg_addr(10'(HS_BASE)), .i_desc_hscfg_len(8'(HS_LEN)),
        .o_tx_valid(tx_valid), .o_tx_data(tx_data), .o_tx_last(tx_last), .o_tx_zlp(tx_zlp),
        .i_tx_ready(tx_ready), .i_pkt_ack(pkt_ack),
        .o_req_stall(req_stall), .o_done(done), .o_busy(busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_quiet(input string tag);
        check(tag, {tx_valid, tx_data, tx_last, tx_zlp, req_stall, done, busy, rom_addr}, 32'd0);
    endtask

    task automatic request(input logic [7:0] typ, input int wlen, input bit hs);
        req_type    = typ;
        req_wlength = 16'(wlen);
        hs_mode     = hs;
        req_valid   = 1'b1;
        @(negedge clk);
        req_valid   = 1'b0;
        check("lookup_busy", 32'(busy), 32'd1);
        check("lookup_valid", 32'(tx_valid), 32'd0);
        @(negedge clk);
    endtask

    task automatic expect_stall(input logic [7:0] typ);
        request(typ, 255, 1'b0);
        check("stall_pulse", 32'(req_stall), 32'd1);
        check("stall_valid", 32'(tx_valid), 32'd0);
        @(negedge clk);
        check_quiet("stall_after");
    endtask

    // n, zlp: hand-computed byte count and ZLP expectation for this request
    task automatic xfer(input logic [7:0] typ, input int wlen, input bit hs, input int base,
                        input int n, input bit zlp, input bit bp, input int abort_at,
                        input bit rst_wait);
        int  guard;
        logic exp_last;
        request(typ, wlen, hs);
        for (int i = 0; i < n; i++) begin
            guard = 0;
            while (!tx_valid && guard < 20) begin
                @(negedge clk);
                guard++;
            end
            check("byte_gap", 32'(guard), 32'd0);
            check("byte_valid", 32'(tx_valid), 32'd1);
            if (i == abort_at) begin
                abort_in = 1'b1;
                @(negedge clk);
                abort_in = 1'b0;
                check_quiet("abort_out");
                repeat (3) begin
                    @(negedge clk);
                    check_quiet("abort_idle");
                end
                return;
            end
            exp_last = (i == n - 1) || ((i % MAXPKT) == MAXPKT - 1);
            if (bp) begin
                while ($urandom_range(0, 1) == 0) begin
                    tx_ready = 1'b0;
                    check("bp_data", 32'(tx_data), 32'(rom[base + i]));
                    check("bp_addr", 32'(rom_addr), 32'(base + i));
                    check("bp_last", 32'(tx_last), 32'(exp_last));
                    @(negedge clk);
                    check("bp_valid", 32'(tx_valid), 32'd1);
                end
            end
            tx_ready = 1'b1;
            check("data", 32'(tx_data), 32'(rom[base + i]));
            check("addr", 32'(rom_addr), 32'(base + i));
            check("last", 32'(tx_last), 32'(exp_last));
            check("zlp_flag", 32'(tx_zlp), 32'd0);
            @(negedge clk);
            if (exp_last) begin
                check("wait_valid", 32'(tx_valid), 32'd0);
                @(negedge clk);
                check("wait_valid2", 32'(tx_valid), 32'd0);
                check("wait_done", 32'(done), 32'd0);
                if (rst_wait) begin
                    rst_n = 1'b0;
                    @(negedge clk);
                    check_quiet("reset_wait_out");
                    rst_n = 1'b1;
                    @(negedge clk);
                    check_quiet("reset_wait_idle");
                    return;
                end
                pkt_ack = 1'b1;
                @(negedge clk);
                pkt_ack = 1'b0;
            end
        end
        if (zlp) begin
            check("zlp_valid", 32'(tx_valid), 32'd1);
            check("zlp_marker", {tx_zlp, tx_last, tx_data}, {1'b1, 1'b1, 8'h00});
            @(negedge clk);
            check("zlp_wait", 32'(tx_valid), 32'd0);
            pkt_ack = 1'b1;
            @(negedge clk);
            pkt_ack = 1'b0;
        end
        check("done_pulse", 32'(done), 32'd1);
        check("done_valid", 32'(tx_valid), 32'd0);
        @(negedge clk);
        check_quiet("done_after");
    endtask

    initial begin
        logic [7:0] dev [0:17];
        dev = '{8'h12, 8'h01, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00, 8'h40, 8'hAA,
                8'h33, 8'h20, 8'h01, 8'h00, 8'h01, 8'h01, 8'h02, 8'h03, 8'h01};
        for (int i = 0; i < 1024; i++) rom[i] = 8'(i * 37 + 5);
        for (int i = 0; i < DEV_LEN; i++) rom[DEV_BASE + i] = dev[i];

        rst_n = 1'b0; req_valid = 1'b0; req_type = 8'd0; req_wlength = 16'd0;
        hs_mode = 1'b0; abort_in = 1'b0; tx_ready = 1'b1; pkt_ack = 1'b0;
        repeat (3) @(negedge clk);
        check_quiet("reset_out");
        rst_n = 1'b1;
        @(negedge clk);

        xfer(8'd1, 64,  1'b0, DEV_BASE, 18, 1'b0, 1'b0, -1, 1'b0);
        xfer(8'd1, 8,   1'b0, DEV_BASE, 8,  1'b0, 1'b0, -1, 1'b0);
        xfer(8'd2, 255, 1'b1, HS_BASE,  32, 1'b1, 1'b0, -1, 1'b0);
        xfer(8'd2, 32,  1'b1, HS_BASE,  32, 1'b0, 1'b0, -1, 1'b0);
        xfer(8'd2, 255, 1'b0, FS_BASE,  25, 1'b0, 1'b0, -1, 1'b0);
        xfer(8'd1, 0,   1'b0, DEV_BASE, 0,  1'b0, 1'b0, -1, 1'b0);
        expect_stall(8'd3);
        expect_stall(8'd6);
        xfer(8'd1, 64,  1'b0, DEV_BASE, 18, 1'b0, 1'b1, -1, 1'b0);
        xfer(8'd2, 255, 1'b1, HS_BASE,  32, 1'b1, 1'b0, 12, 1'b0);
        xfer(8'd1, 64,  1'b0, DEV_BASE, 18, 1'b0, 1'b0, -1, 1'b0);
        xfer(8'd2, 255, 1'b1, HS_BASE,  32, 1'b1, 1'b0, -1, 1'b1);
        xfer(8'd1, 18,  1'b0, DEV_BASE, 18, 1'b0, 1'b0, -1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/usb_desc_streamer.md
# usb_desc_streamer

Control-endpoint descriptor engine that sits directly downstream of the descriptor ROM. On a decoded GET_DESCRIPTOR request it looks up the descriptor base address and length from the ROM's address/length outputs. It clips the length to wLength, reads the ROM byte by byte and streams the bytes to the EP0 IN transmitter as packets of at most MAXPKT bytes. It inserts a zero-length packet (ZLP) where USB 2.0 requires one, and stalls unsupported descriptor types.

## Interface
- MAXPKT, 64: EP0 max packet size in bytes; legal values 8, 16, 32, 64.
- HSSUPPORT, 1: when 0, the device qualifier descriptor (type 6) stalls.
- CLK  in  1  sole clock. RESET  in  1  synchronous, active-low reset.
- i_req_valid  in  1  one-cycle GET_DESCRIPTOR strobe.
- i_req_type  in  8  wValue[15:8]. i_req_wlength  in  16  wLength.
- i_hs_mode  in  1  link is currently high speed. i_abort  in  1  new SETUP or bus reset; cancels the transfer.
- o_descrom_raddr  out  10  ROM read address. i_descrom_rdat  in  8  ROM data, combinational from raddr.
- i_desc_dev_addr/len, i_desc_qual_addr/len, i_desc_fscfg_addr/len, i_desc_hscfg_addr/len  in  10/8 each  region table from the ROM.
- o_tx_valid  out  1. o_tx_data  out  8. o_tx_last  out  1  last byte of packet. o_tx_zlp  out  1  zero-length packet marker, qualified by o_tx_valid. i_tx_ready  in  1.
- i_pkt_ack  in  1  host ACKed the packet just sent.
- o_req_stall  out  1  one-cycle pulse. o_done  out  1  one-cycle pulse when the data stage completes. o_busy  out  1.

## Operation
- States: IDLE, LOOKUP, SEND, WAIT_ACK, ZLP, DONE.
- IDLE: i_req_valid is accepted only in IDLE and is ignored in all other states. On accept, latch type, wLength and i_hs_mode, then go to LOOKUP.
- LOOKUP: select the region.
  - Type 1 selects dev.
  - Type 2 selects hscfg if hs_mode, else fscfg.
  - Type 6 selects qual if HSSUPPORT, else stall.
  - Any other type stalls.
  - On stall: pulse o_req_stall and return to IDLE.
  - Otherwise set ptr=base and remaining=min({8'b0,len}, wLength) using a 16-bit compare. Reset the packet byte count pc=0 and total=0.
  - If remaining==0, go to DONE; else go to SEND.
- SEND: o_tx_valid=1, o_descrom_raddr=ptr, o_tx_data=i_descrom_rdat. o_tx_last=1 when remaining==1 or pc==MAXPKT-1.
  - On valid&&ready: ptr+1, remaining-1, pc+1, total+1.
  - When the last byte is accepted, go to WAIT_ACK.
- WAIT_ACK: wait for i_pkt_ack, then decide:
  - If remaining>0: clear pc and go to SEND.
  - Else, if the final packet was exactly MAXPKT bytes and total<wLength: go to ZLP.
  - Otherwise go to DONE.
- ZLP: o_tx_valid=1, o_tx_zlp=1, o_tx_last=1, o_tx_data=0. When accepted, go to WAIT_ACK. After that ack, go to DONE.
- DONE: pulse o_done for one cycle, then go to IDLE.
- i_abort in any state forces IDLE next cycle, with no o_done and no o_req_stall. Abort has priority over all other events, including a same-cycle i_req_valid or handshake.
- o_busy=1 in every state except IDLE.
- Width rules: ptr is 10 bits; wrap is not expected, but if it occurs it is modulo 1024. remaining and total are 16 bits. pc uses $clog2(MAXPKT)+1 bits.

## Timing
- Reset (RESET low at an edge): state IDLE. All outputs 0: o_tx_valid, o_tx_data, o_tx_last, o_tx_zlp, o_req_stall, o_done, o_busy, o_descrom_raddr=0. Reset mid-transfer discards all progress.
- i_req_valid sampled at edge k: LOOKUP holds during cycle k+1. From edge k+2, either o_tx_valid=1 (first byte) or o_req_stall=1 for one cycle.
- Throughput is one byte per cycle while i_tx_ready is held high. When i_tx_ready=0, o_tx_valid, o_tx_data, o_tx_last and o_descrom_raddr hold stable.
- o_tx_valid stays low from the cycle after the last-byte handshake until the cycle after i_pkt_ack.
- i_pkt_ack outside WAIT_ACK is ignored.
- o_done is asserted in the cycle after the final ack. For wLength=0 it is asserted in the cycle after LOOKUP.

## Test plan
- Device descriptor with wLength=64, MAXPKT=64 -> one packet of 18 bytes starting 12 01 00 02 00 00 00 40 AA 33 20 01; o_tx_last on byte 18; no ZLP; o_done after the ack.
- Device descriptor with wLength=8 -> 8 bytes, last on byte 8, no ZLP (total==wLength).
- HS config (len 32) with MAXPKT=8, wLength=255, hs_mode=1 -> packets of 8/8/8/8, each gated on i_pkt_ack, then a ZLP, then o_done. Repeat with wLength=32 -> no ZLP.
- Type 3 (string) and type 6 with HSSUPPORT=0 -> o_req_stall pulses exactly 2 cycles after the request; o_tx_valid is never asserted.
- Random i_tx_ready backpressure during the device descriptor -> byte stream identical to the no-backpressure case; data is stable while stalled.
- i_abort in the 5th byte of packet 2, and separately RESET low in WAIT_ACK -> IDLE next cycle, all outputs 0, no o_done. A new request is then served correctly.
